// File: rtl/plab5_mcore_dma_req_arbiter_pkg.sv
// rtl/plab5_mcore_dma_req_arbiter_pkg.sv - shared encodings and widths for the DMA request arbiter
package plab5_mcore_dma_req_arbiter_pkg;

    // Memory request control: type(3) + opaque(8) + addr(32) + len(2)
    localparam int c_vc_mem_req_cnbits  = 45;
    // Memory response control: type(3) + opaque(8) + len(2)
    localparam int c_vc_mem_resp_cnbits = 13;
    // Width of the WAIT-state watchdog counter
    localparam int c_wait_cnt_nbits     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Index width for a requester vector; never narrower than one bit
    function automatic int ptr_nbits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/plab5_mcore_rr_prio_picker.sv
// rtl/plab5_mcore_rr_prio_picker.sv - circular priority encoder starting at a round-robin pointer
module plab5_mcore_rr_prio_picker
    import plab5_mcore_dma_req_arbiter_pkg::*;
#(
    parameter int p_num_req   = 4,
    parameter int p_ptr_nbits = 2
) (
    input  logic [p_num_req-1:0]   val_i,
    input  logic [p_num_req-1:0]   mask_i,
    input  logic [p_ptr_nbits-1:0] rr_ptr_i,
    output logic [p_ptr_nbits-1:0] grant_o,
    output logic                   any_o
);

    logic [p_num_req-1:0] cand;

    // Walk the requesters starting at rr_ptr_i and stop at the first masked-in valid one
    always_comb begin
        int   idx;
        logic found;
        cand    = val_i & mask_i;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < p_num_req; k++) begin
            idx = (int'(rr_ptr_i) + k) % p_num_req;
            if (!found && cand[idx]) begin
                grant_o = p_ptr_nbits'(idx);
                found   = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/plab5_mcore_dma_req_arbiter.sv
// rtl/plab5_mcore_dma_req_arbiter.sv - round-robin arbiter sharing the DMA checker request port
module plab5_mcore_dma_req_arbiter
    import plab5_mcore_dma_req_arbiter_pkg::*;
#(
    parameter int p_num_req     = 4,
    parameter int p_addr_nbits  = 32,
    parameter int p_req_cnbits  = c_vc_mem_req_cnbits,
    parameter int p_resp_cnbits = c_vc_mem_resp_cnbits,
    parameter int p_timeout     = 255,
    parameter int p_secure_prio = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_req-1:0]              req_val,
    output logic [p_num_req-1:0]              req_rdy,
    input  logic [p_num_req-1:0]              req_domain,
    input  logic [p_num_req*p_addr_nbits-1:0] req_src_addr,
    input  logic [p_num_req*p_addr_nbits-1:0] req_dest_addr,
    input  logic [p_num_req*p_req_cnbits-1:0] req_control,
    output logic [p_num_req-1:0]              req_ack,
    output logic [p_num_req-1:0]              req_err,
    output logic [p_resp_cnbits-1:0]          req_resp_control,
    output logic                              req_resp_domain,
    output logic                              chk_val,
    input  logic                              chk_rdy,
    output logic                              chk_domain,
    output logic [p_addr_nbits-1:0]           chk_src_addr,
    output logic [p_addr_nbits-1:0]           chk_dest_addr,
    output logic [p_req_cnbits-1:0]           chk_req_control,
    output logic                              chk_inst,
    input  logic                              chk_ack,
    input  logic                              chk_resp_domain,
    input  logic [p_resp_cnbits-1:0]          chk_resp_control
);

    localparam int p_ptr_nbits = ptr_nbits(p_num_req);
    localparam logic [c_wait_cnt_nbits-1:0] c_timeout = c_wait_cnt_nbits'(p_timeout);
    localparam logic [p_ptr_nbits-1:0]      c_last    = p_ptr_nbits'(p_num_req - 1);

    arb_state_e                  state_q, state_d;
    logic [p_ptr_nbits-1:0]      rr_ptr_q, rr_ptr_d;
    logic [p_ptr_nbits-1:0]      grant_q, grant_d;
    logic                        dom_q, dom_d;
    logic [p_addr_nbits-1:0]     src_q, src_d;
    logic [p_addr_nbits-1:0]     dest_q, dest_d;
    logic [p_req_cnbits-1:0]     ctrl_q, ctrl_d;
    logic [c_wait_cnt_nbits-1:0] wait_cnt_q, wait_cnt_d;
    logic                        err_q, err_d;
    logic [p_resp_cnbits-1:0]    resp_ctrl_q, resp_ctrl_d;

    logic [p_num_req-1:0]        prio_mask;
    logic [p_ptr_nbits-1:0]      pick;
    logic                        pick_any;

    // With secure priority, any valid domain-1 requester hides all domain-0 requesters
    always_comb begin
        prio_mask = '1;
        if ((p_secure_prio != 0) && (|(req_val & req_domain))) begin
            prio_mask = req_domain;
        end
    end

    plab5_mcore_rr_prio_picker #(
        .p_num_req   (p_num_req),
        .p_ptr_nbits (p_ptr_nbits)
    ) u_picker (
        .val_i    (req_val),
        .mask_i   (prio_mask),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick),
        .any_o    (pick_any)
    );

    // State register and latched transaction fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            dom_q       <= 1'b0;
            src_q       <= '0;
            dest_q      <= '0;
            ctrl_q      <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            resp_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            dom_q       <= dom_d;
            src_q       <= src_d;
            dest_q      <= dest_d;
            ctrl_q      <= ctrl_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            resp_ctrl_q <= resp_ctrl_d;
        end
    end

    // Next-state: accept in IDLE, hand off in ISSUE, watch for ack or timeout in WAIT
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        dom_d       = dom_q;
        src_d       = src_q;
        dest_d      = dest_q;
        ctrl_d      = ctrl_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        resp_ctrl_d = resp_ctrl_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick;
                    dom_d   = req_domain[pick];
                    src_d   = req_src_addr[int'(pick)*p_addr_nbits +: p_addr_nbits];
                    dest_d  = req_dest_addr[int'(pick)*p_addr_nbits +: p_addr_nbits];
                    ctrl_d  = req_control[int'(pick)*p_req_cnbits +: p_req_cnbits];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (chk_rdy) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // wait_cnt_d is the number of WAIT cycles elapsed including this one
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (chk_ack && (chk_resp_domain == dom_q)) begin
                    resp_ctrl_d = chk_resp_control;
                    err_d       = 1'b0;
                    state_d     = ST_RESP;
                end else if (wait_cnt_d == c_timeout) begin
                    resp_ctrl_d = '0;
                    err_d       = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (grant_q == c_last) ? '0 : grant_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Requester-side handshake and response strobes; req_rdy is gated so nothing leaks during reset
    always_comb begin
        req_rdy          = '0;
        req_ack          = '0;
        req_err          = '0;
        req_resp_control = '0;
        req_resp_domain  = 1'b0;
        if (reset && (state_q == ST_IDLE) && pick_any) begin
            req_rdy[pick] = 1'b1;
        end
        if (state_q == ST_RESP) begin
            req_ack[grant_q] = 1'b1;
            req_err[grant_q] = err_q;
            req_resp_control = resp_ctrl_q;
            req_resp_domain  = dom_q;
        end
    end

    assign chk_val         = (state_q == ST_ISSUE);
    assign chk_domain      = dom_q;
    assign chk_src_addr    = src_q;
    assign chk_dest_addr   = dest_q;
    assign chk_req_control = ctrl_q;
    assign chk_inst        = 1'b0;

endmodule
